mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, data port, memory port and status.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        busy;

  // Arbiter side: serves the two requesters and masters the memory.
  modport slave (
    input  if_req, if_addr,
    output if_ack, if_err, if_rdata,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_ack, d_err, d_rdata,
    output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output busy
  );

  // Environment side: requesters plus the memory model.
  modport master (
    output if_req, if_addr,
    input  if_ack, if_err, if_rdata,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_ack, d_err, d_rdata,
    input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between instruction fetch
// and data access, with alignment check on data and a wait-cycle timeout.
//
// state | meaning
// IDLE  | no access; requests sampled here, data wins over fetch
// FETCH | fetch access presented to memory, waiting for mem_ready
// DATA  | load/store presented to memory, waiting for mem_ready
// RESP  | one-cycle ack (and err) to the requester that was served
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       srv_d;
  logic       d_misalign;
  logic       resp_d;
  logic       resp_err;
  logic       acc_done;

  // Byte accesses are always aligned; size code 11 is not a legal RV32I size.
  assign d_misalign = ((bus.d_funct3[1:0] == 2'b01) && bus.d_addr[0]) ||
                      ((bus.d_funct3[1:0] == 2'b10) && (bus.d_addr[1:0] != 2'b00));

  assign bus.busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus classification of the response about to be issued.
  always_comb begin
    state_nxt = state;
    resp_d    = srv_d;
    resp_err  = 1'b0;
    acc_done  = 1'b0;
    unique case (state)
      IDLE: begin
        // Only the data port can go straight to RESP (misaligned request).
        resp_d = 1'b1;
        if (bus.d_req) begin
          if (d_misalign) begin
            state_nxt = RESP;
            resp_err  = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end else if (bus.if_req) begin
          state_nxt = FETCH;
        end
      end
      FETCH, DATA: begin
        // A ready arriving on the last allowed wait cycle still succeeds.
        if (bus.mem_ready) begin
          state_nxt = RESP;
          acc_done  = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = RESP;
          resp_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured request, memory port registers, wait counter and responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt       <= 8'd0;
      srv_d          <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_funct3 <= 3'b010;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      bus.if_ack     <= 1'b0;
      bus.if_err     <= 1'b0;
      bus.if_rdata   <= 32'd0;
      bus.d_ack      <= 1'b0;
      bus.d_err      <= 1'b0;
      bus.d_rdata    <= 32'd0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.if_err <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.d_err  <= 1'b0;

      if (state == IDLE) begin
        wait_cnt <= 8'd0;
        if (state_nxt == DATA) begin
          srv_d          <= 1'b1;
          bus.mem_req    <= 1'b1;
          bus.mem_we     <= bus.d_we;
          bus.mem_funct3 <= bus.d_funct3;
          bus.mem_addr   <= bus.d_addr;
          bus.mem_wdata  <= bus.d_wdata;
        end else if (state_nxt == FETCH) begin
          srv_d          <= 1'b0;
          bus.mem_req    <= 1'b1;
          bus.mem_we     <= 1'b0;
          bus.mem_funct3 <= 3'b010;
          bus.mem_addr   <= bus.if_addr;
          bus.mem_wdata  <= 32'd0;
        end
      end else if (!bus.mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (state_nxt == RESP) begin
        bus.mem_req    <= 1'b0;
        bus.mem_we     <= 1'b0;
        bus.mem_funct3 <= 3'b010;
        bus.mem_addr   <= 32'd0;
        bus.mem_wdata  <= 32'd0;
        bus.if_ack     <= !resp_d;
        bus.if_err     <= !resp_d && resp_err;
        bus.d_ack      <= resp_d;
        bus.d_err      <= resp_d && resp_err;
        if (acc_done) begin
          if (!srv_d)            bus.if_rdata <= bus.mem_rdata;
          else if (!bus.mem_we)  bus.d_rdata  <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          mem_lat = 0;
  int          mem_cyc = 0;
  logic [31:0] mem_data = 32'd0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata  = 32'd0;

  logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
  int          mode;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_ia, r_da, r_dw;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":busy"}, bus.busy, 1'b0);
    chk({tag, ":mem_req"}, bus.mem_req, 1'b0);
    chk({tag, ":mem_we"}, bus.mem_we, 1'b0);
    chk({tag, ":mem_funct3"}, bus.mem_funct3, 3'b010);
    chk({tag, ":mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, ":mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, ":acks_errs"}, {bus.if_ack, bus.d_ack, bus.if_err, bus.d_err}, 4'b0000);
    chk({tag, ":if_rdata"}, bus.if_rdata, 32'd0);
    chk({tag, ":d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  // Memory: ready after mem_lat wait cycles of mem_req; noise while idle.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        bus.mem_ready = (mem_cyc >= mem_lat);
        bus.mem_rdata = bus.mem_ready ? mem_data : $urandom;
        mem_cyc++;
      end else begin
        mem_cyc = 0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // One arbitrated access: optionally raise new requests, then follow it to its ack.
  task automatic access(input string tag, input bit new_if, input logic [31:0] ia,
                        input bit new_d, input logic dwe, input logic [2:0] df3,
                        input logic [31:0] da, input logic [31:0] dw,
                        input int lat, input logic [31:0] data);
    bit          srv_d, mis, ok, done;
    int          n_exp, mcyc, ack_k;
    logic [67:0] mexp;
    @(negedge clk);
    chk({tag, ":idle_busy"}, bus.busy, 1'b0);
    if (new_if) begin
      bus.if_req  = 1'b1;
      bus.if_addr = ia;
    end
    if (new_d) begin
      bus.d_req    = 1'b1;
      bus.d_we     = dwe;
      bus.d_funct3 = df3;
      bus.d_addr   = da;
      bus.d_wdata  = dw;
    end
    mem_lat  = lat;
    mem_data = data;
    srv_d = bus.d_req;
    if (srv_d) begin
      mis  = (bus.d_funct3[1:0] == 2'b01 && bus.d_addr[0] == 1'b1) ||
             (bus.d_funct3[1:0] == 2'b10 && bus.d_addr[1:0] != 2'b00);
      mexp = {bus.d_we, bus.d_funct3, bus.d_addr, bus.d_wdata};
    end else begin
      mis  = 1'b0;
      mexp = {1'b0, 3'b010, bus.if_addr, 32'd0};
    end
    ok    = !mis && (lat < TO);
    n_exp = mis ? 0 : ((lat < TO) ? lat + 1 : TO);
    mcyc  = 0;
    done  = 1'b0;
    ack_k = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        mcyc++;
        chk({tag, ":mem_ctrl"}, {bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata}, mexp);
      end
      if (bus.if_ack || bus.d_ack) begin
        done  = 1'b1;
        ack_k = k;
      end
    end
    chk({tag, ":ack_seen"}, done, 1'b1);
    if (done) begin
      chk({tag, ":ack_latency"}, ack_k, n_exp + 1);
      chk({tag, ":mem_cycles"}, mcyc, n_exp);
      chk({tag, ":ack_which"}, {bus.if_ack, bus.d_ack}, srv_d ? 2'b01 : 2'b10);
      chk({tag, ":err"}, {bus.if_err, bus.d_err}, srv_d ? {1'b0, !ok} : {!ok, 1'b0});
      chk({tag, ":mem_req_resp"}, bus.mem_req, 1'b0);
      if (ok && !srv_d) exp_if_rdata = data;
      if (ok && srv_d && !bus.d_we) exp_d_rdata = data;
      chk({tag, ":if_rdata"}, bus.if_rdata, exp_if_rdata);
      chk({tag, ":d_rdata"}, bus.d_rdata, exp_d_rdata);
      if (srv_d) bus.d_req  = 1'b0;
      else       bus.if_req = 1'b0;
    end
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_funct3 = 3'b010;
    bus.d_addr   = 32'd0;
    bus.d_wdata  = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Single fetch with a one-cycle memory.
    access("fetch40", 1'b1, 32'h40, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 0, 32'h0050_0093);

    // Simultaneous requests: data first, then the still-pending fetch.
    access("both_d", 1'b1, 32'h80, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hCAFE_0001);
    access("both_if", 1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1, 32'hCAFE_0002);

    // Misaligned halfword store never reaches memory.
    access("sh_mis", 1'b0, 32'd0, 1'b1, 1'b1, 3'b001, 32'h103, 32'h1234_5678, 0, 32'hDEAD_0000);

    // Misaligned word load never reaches memory.
    access("lw_mis", 1'b0, 32'd0, 1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 0, 32'hDEAD_0001);

    // Misaligned-looking fetch is passed through.
    access("fetch_odd", 1'b1, 32'h203, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 2, 32'h1111_2222);

    // Timeout: memory never answers.
    access("lw_timeout", 1'b0, 32'd0, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 200, 32'hBAD0_BAD0);

    // Ready on the last allowed cycle still succeeds.
    access("lw_lastcyc", 1'b0, 32'd0, 1'b1, 1'b0, 3'b010, 32'h304, 32'd0, TO - 1, 32'h600D_600D);

    // Fetch timeout keeps the previous fetch data.
    access("if_timeout", 1'b1, 32'h500, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, TO, 32'hBAD1_BAD1);

    // Store success leaves d_rdata alone.
    access("sw_ok", 1'b0, 32'd0, 1'b1, 1'b1, 3'b010, 32'h400, 32'hA5A5_5A5A, 1, 32'h7777_7777);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      r_we = 1'($urandom_range(0, 1));
      r_f3 = r_we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      r_ia = $urandom;
      r_da = $urandom;
      r_dw = $urandom;
      if ($urandom_range(0, 1) == 1) r_da[1:0] = 2'b00;
      case (mode)
        0: access("rnd_if", 1'b1, r_ia, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0,
                  $urandom_range(0, 5), $urandom);
        1: access("rnd_d", 1'b0, 32'd0, 1'b1, r_we, r_f3, r_da, r_dw,
                  $urandom_range(0, 5), $urandom);
        default: begin
          access("rnd_both_d", 1'b1, r_ia, 1'b1, r_we, r_f3, r_da, r_dw,
                 $urandom_range(0, 5), $urandom);
          access("rnd_both_if", 1'b0, 32'd0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0,
                 $urandom_range(0, 5), $urandom);
        end
      endcase
    end

    // Reset during DATA while memory is ready: access is abandoned.
    @(negedge clk);
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_funct3 = 3'b010;
    bus.d_addr   = 32'h600;
    mem_lat      = 0;
    mem_data     = 32'hFEED_F00D;
    @(negedge clk);
    #1;
    chk("rst_mid:in_data", {bus.mem_req, bus.busy, bus.mem_ready}, 3'b111);
    rst       = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b0;
    exp_if_rdata = 32'd0;
    exp_d_rdata  = 32'd0;

    access("after_rst", 1'b1, 32'h44, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 0, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
